wb_aes_regs: RTL and testbench



---
 rtl/wb_aes_regs.sv | 146 ++++++++++++++
 tb/tb_wb_aes_regs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_aes_regs.sv
// wb_aes_regs: Wishbone B3 classic register slave in front of the AES core.
// Holds key/plaintext, launches the core, watches for a hung core, latches ciphertext.
module wb_aes_regs #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [31:0]  wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    input  logic [3:0]   wb_sel_i,
    input  logic         wb_we_i,
    input  logic         wb_cyc_i,
    input  logic         wb_stb_i,
    output logic [31:0]  wb_dat_o,
    output logic         wb_ack_o,
    output logic         wb_err_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_pt_o,
    output logic         core_start_o,
    input  logic [127:0] core_ct_i,
    input  logic         core_valid_i,
    output logic         int_o
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          busy;
    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   dat_q, dat_d, rdata;
    logic          ie_q, ie_d, done_q, done_d, tout_q, tout_d;
    logic          start_pend_q, start_pend_d, start_q, start_d;
    logic [127:0]  key_q, key_d, pt_q, pt_d, ct_q, ct_d;
    logic [15:0]   wdog_q, wdog_d;
    logic          req, bad, wr_ok, go, complete, timeout;
    logic [4:0]    idx;
    logic [1:0]    word;
    logic          is_ctrl, is_status, is_key, is_pt, is_ct, mapped;
    logic          unused_adr;

    // Handshake: a request is cyc&stb while no termination is showing. It is answered by
    // exactly one registered ack or err the following cycle; a strobe still held then is ignored.
    assign req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign idx       = wb_adr_i[6:2];
    assign word      = idx[1:0];
    assign is_ctrl   = (idx == 5'd0);
    assign is_status = (idx == 5'd1);
    assign is_key    = (idx[4:2] == 3'b001);
    assign is_pt     = (idx[4:2] == 3'b010);
    assign is_ct     = (idx[4:2] == 3'b011);
    assign mapped    = is_ctrl | is_status | is_key | is_pt | is_ct;
    assign bad       = ~mapped | (wb_we_i & is_ct) | (wb_we_i & (is_key | is_pt) & busy)
                     | (wb_we_i & is_ctrl & wb_dat_i[0] & busy);
    assign wr_ok     = req & wb_we_i & ~bad;
    assign go        = wr_ok & is_ctrl & wb_dat_i[0];
    assign complete  = busy & core_valid_i;
    assign timeout   = busy & ~core_valid_i & (wdog_q == WDOG_LAST);
    assign unused_adr = ^{wb_adr_i[31:7], wb_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_BUSY;
            S_BUSY: if (complete | timeout) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == S_BUSY);
        int_o        = ie_q & (done_q | tout_q);
        core_start_o = start_q;
        wb_ack_o     = ack_q;
        wb_err_o     = err_q;
        wb_dat_o     = dat_q;
        core_key_o   = key_q;
        core_pt_o    = pt_q;
    end

    always_comb begin
        rdata = '0;
        if (is_ctrl)        rdata = {30'd0, ie_q, 1'b0};
        else if (is_status) rdata = {29'd0, tout_q, done_q, busy};
        else if (is_key)    rdata = key_q[{~word, 5'd0} +: 32];
        else if (is_pt)     rdata = pt_q[{~word, 5'd0} +: 32];
        else if (is_ct)     rdata = ct_q[{~word, 5'd0} +: 32];
    end

    always_comb begin
        ack_d        = req & ~bad;
        err_d        = req & bad;
        dat_d        = (req & ~bad & ~wb_we_i) ? rdata : 32'd0;
        ie_d         = ie_q;
        key_d        = key_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        wdog_d       = wdog_q;
        start_pend_d = go;
        start_d      = start_pend_q;
        if (go)        wdog_d = '0;
        else if (busy) wdog_d = wdog_q + 16'd1;
        if (wr_ok & is_ctrl) ie_d = wb_dat_i[1];
        // A completion or timeout landing with a W1C of the same bit keeps the bit set.
        done_d = (done_q & ~(wr_ok & is_status & wb_dat_i[1])) | complete;
        tout_d = (tout_q & ~(wr_ok & is_status & wb_dat_i[2])) | timeout;
        if (complete) ct_d = core_ct_i;
        for (int b = 0; b < 4; b++) begin
            if (wr_ok & is_key & wb_sel_i[b]) key_d[{~word, 2'(b), 3'd0} +: 8] = wb_dat_i[8*b +: 8];
            if (wr_ok & is_pt & wb_sel_i[b])  pt_d[{~word, 2'(b), 3'd0} +: 8]  = wb_dat_i[8*b +: 8];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            tout_q       <= 1'b0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            key_q        <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            wdog_q       <= '0;
        end else begin
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_q        <= dat_d;
            ie_q         <= ie_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
            start_pend_q <= start_pend_d;
            start_q      <= start_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            wdog_q       <= wdog_d;
        end
    end
endmodule

// File: tb/tb_wb_aes_regs.sv
// Directed bench for wb_aes_regs: one instance at the default watchdog, one with an
// 8-cycle watchdog; bus stimulus is shared and cyc selects which instance is addressed.
module tb_wb_aes_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  adr, wdat;
    logic [3:0]   sel;
    logic         we, stb, cyc_a, cyc_b;
    logic [127:0] core_ct;
    logic         core_valid;
    logic         which;

    logic [31:0]  dat_a, dat_b;
    logic         ack_a, ack_b, err_a, err_b, start_a, start_b, int_a, int_b;
    logic [127:0] key_a, key_b, pt_a, pt_b;

    logic [31:0]  dat_m;
    logic         ack_m, err_m, start_m, int_m;
    logic [127:0] key_m, pt_m;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int sc0;

    wb_aes_regs u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
        .wb_err_o(err_a), .core_key_o(key_a), .core_pt_o(pt_a), .core_start_o(start_a),
        .core_ct_i(core_ct), .core_valid_i(core_valid), .int_o(int_a)
    );

    wb_aes_regs #(.TIMEOUT_CYCLES(8)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_dat_o(dat_b), .wb_ack_o(ack_b),
        .wb_err_o(err_b), .core_key_o(key_b), .core_pt_o(pt_b), .core_start_o(start_b),
        .core_ct_i(core_ct), .core_valid_i(core_valid), .int_o(int_b)
    );

    assign dat_m   = which ? dat_b : dat_a;
    assign ack_m   = which ? ack_b : ack_a;
    assign err_m   = which ? err_b : err_a;
    assign start_m = which ? start_b : start_a;
    assign int_m   = which ? int_b : int_a;
    assign key_m   = which ? key_b : key_a;
    assign pt_m    = which ? pt_b : pt_a;

    always @(negedge clk) if (start_m) start_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic [31:0] rd, output logic ak, output logic er);
        adr = a; wdat = d; sel = s; we = w; stb = 1'b1;
        if (which) cyc_b = 1'b1; else cyc_a = 1'b1;
        rd = '0; ak = 1'b0; er = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack_m | err_m) begin
                ak = ack_m; er = err_m; rd = dat_m;
                break;
            end
        end
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic ak, er;
        xfer(a, d, s, 1'b1, rd, ak, er);
        check({tag, "_ack"}, {126'd0, ak, er}, 128'b10);
    endtask

    task automatic wr_err(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic ak, er;
        xfer(a, d, 4'hF, 1'b1, rd, ak, er);
        check({tag, "_err"}, {126'd0, ak, er}, 128'b01);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic ak, er;
        xfer(a, 32'd0, 4'hF, 1'b0, rd, ak, er);
        check({tag, "_ack"}, {126'd0, ak, er}, 128'b10);
        check({tag, "_data"}, {96'd0, rd}, {96'd0, exp});
    endtask

    task automatic rd_err(input string tag, input logic [31:0] a);
        logic [31:0] rd; logic ak, er;
        xfer(a, 32'd0, 4'hF, 1'b0, rd, ak, er);
        check({tag, "_err"}, {126'd0, ak, er}, 128'b01);
        check({tag, "_data"}, {96'd0, rd}, 128'd0);
    endtask

    task automatic pulse_valid(input logic [127:0] ct);
        core_ct = ct; core_valid = 1'b1;
        @(posedge clk); #1;
        core_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0;
        cyc_a = 1'b0; cyc_b = 1'b0; core_ct = '0; core_valid = 1'b0; which = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_ack", {127'd0, ack_m}, 128'd0);
        check("rst_err", {127'd0, err_m}, 128'd0);
        check("rst_dat", {96'd0, dat_m}, 128'd0);
        check("rst_start", {127'd0, start_m}, 128'd0);
        check("rst_int", {127'd0, int_m}, 128'd0);
        rd_chk("status_rst", 32'h04, 32'h0);
        rd_chk("ct0_rst", 32'h30, 32'h0);

        // byte-enabled key write
        wr_ok("key0_wr", 32'h10, 32'h2B7E1516, 4'b0011);
        rd_chk("key0_rd", 32'h10, 32'h00001516);
        check("core_key_hi", {96'd0, key_m[127:96]}, 128'h00001516);

        // plaintext and start
        wr_ok("pt0", 32'h20, 32'h6BC1BEE2, 4'hF);
        wr_ok("pt1", 32'h24, 32'h2E409F96, 4'hF);
        wr_ok("pt2", 32'h28, 32'hE93D7E11, 4'hF);
        wr_ok("pt3", 32'h2C, 32'h7393172A, 4'hF);
        check("core_pt", pt_m, 128'h6BC1BEE2_2E409F96_E93D7E11_7393172A);
        sc0 = start_cnt;
        wr_ok("ctrl_go", 32'h00, 32'h3, 4'hF);
        check("start_in_ack", {127'd0, start_m}, 128'd0);
        @(posedge clk); #1;
        check("start_pulse", {127'd0, start_m}, 128'd1);
        @(posedge clk); #1;
        check("start_end", {127'd0, start_m}, 128'd0);
        rd_chk("status_busy", 32'h04, 32'h1);

        // illegal accesses while busy
        wr_err("key1_busy", 32'h14, 32'h11111111);
        wr_err("start_busy", 32'h00, 32'h1);
        rd_err("unmapped_40", 32'h40);
        rd_chk("key1_kept", 32'h14, 32'h0);
        rd_chk("ie_kept", 32'h00, 32'h2);
        rd_chk("ct_busy_prev", 32'h30, 32'h0);
        check("single_start", start_cnt, sc0 + 1);

        // core completes
        repeat (4) @(posedge clk);
        #1;
        pulse_valid(128'h3925841D_02DC09FB_DC118597_196A0B32);
        check("int_done", {127'd0, int_m}, 128'd1);
        rd_chk("status_done", 32'h04, 32'h2);
        rd_chk("ct0", 32'h30, 32'h3925841D);
        rd_chk("ct3", 32'h3C, 32'h196A0B32);
        wr_ok("w1c_done", 32'h04, 32'h2, 4'hF);
        check("int_cleared", {127'd0, int_m}, 128'd0);
        rd_chk("status_clr", 32'h04, 32'h0);

        // misc decode
        wr_ok("key0_hi_bytes", 32'h10, 32'hAABBCCDD, 4'b1100);
        rd_chk("key0_lowbits_ign", 32'h13, 32'hAABB1516);
        rd_err("unmapped_08", 32'h08);
        wr_err("ct_write", 32'h30, 32'hFFFFFFFF);
        rd_chk("ct0_kept", 32'h30, 32'h3925841D);

        // watchdog on the 8-cycle instance
        which = 1'b1;
        wr_ok("b_go", 32'h00, 32'h3, 4'hF);
        repeat (7) @(posedge clk);
        #1;
        check("tout_not_yet", {127'd0, int_m}, 128'd0);
        @(posedge clk); #1;
        check("tout_int", {127'd0, int_m}, 128'd1);
        rd_chk("b_status_tout", 32'h04, 32'h4);
        rd_chk("b_ct_unchanged", 32'h30, 32'h0);
        pulse_valid(128'hDEADBEEF_00000000_00000000_12345678);
        rd_chk("b_idle_valid", 32'h04, 32'h4);
        rd_chk("b_ct_idle", 32'h30, 32'h0);
        wr_ok("b_w1c_tout", 32'h04, 32'h4, 4'hF);
        rd_chk("b_status_clr", 32'h04, 32'h0);

        // reset collides with a START request
        which = 1'b0;
        adr = 32'h0; wdat = 32'h1; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc_a = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_no_ack", {126'd0, ack_m, err_m}, 128'd0);
        cyc_a = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_start1", {126'd0, start_m, ack_m}, 128'd0);
        @(posedge clk); #1;
        check("rst_no_start2", {127'd0, start_m}, 128'd0);
        rd_chk("rst_status", 32'h04, 32'h0);
        rd_chk("rst_ctrl", 32'h00, 32'h0);
        rd_chk("rst_key0", 32'h10, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
